// File: rtl/spike_class_decoder.sv
// spike_class_decoder
//   Counts output-layer AER spikes per class over one classification window,
//   then scans the counters sequentially and reports the argmax class through
//   a valid/ready handshake. Counters clear on the handshake and the next
//   window starts on the following edge.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   spike_in      spike event valid (one per cycle max)
//   addr_in[2:0]  spiking neuron address, qualified by spike_in
//   window_end    single-cycle pulse closing the current window
//   result_ready  consumer accepts the result
//   class_valid   result available
//   class_out     winning class address
//   max_count     spike count of the winning class
//   lost          sticky: spike/window_end dropped or counter saturated
//   busy          high whenever not accumulating
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_ACCUM | counting spikes, waiting for window_end
// ST_SCAN  | comparing one counter per cycle, idx 0..N_CLASSES-1
// ST_HOLD  | presenting result until result_ready
module spike_class_decoder #(
  parameter int N_CLASSES = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic [2:0]       addr_in,
  input  logic             window_end,
  input  logic             result_ready,
  output logic             class_valid,
  output logic [2:0]       class_out,
  output logic [CNT_W-1:0] max_count,
  output logic             lost,
  output logic             busy
);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [3:0] N_LIM    = 4'(N_CLASSES);
  localparam logic [2:0] LAST_IDX = 3'(N_CLASSES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt [N_CLASSES];
  logic [2:0]       idx;
  logic [2:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;

  logic             addr_ok;
  logic             handshake;
  logic             lost_set;
  logic [CNT_W-1:0] cnt_sel;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_gt;

  assign addr_ok   = ({1'b0, addr_in} < N_LIM);
  assign handshake = (state == ST_HOLD) && result_ready;
  assign busy      = (state != ST_ACCUM);

  always_comb begin
    cnt_sel = '0;
    if (addr_ok) cnt_sel = cnt[addr_in];
  end

  assign scan_cnt = cnt[idx];
  // strict compare keeps the lowest address on ties
  assign scan_gt  = (scan_cnt > best_cnt);

  always_comb begin
    lost_set = 1'b0;
    if (state == ST_ACCUM) begin
      // a spike hitting an already saturated counter is a lost event
      if (spike_in && (!addr_ok || (cnt_sel == '1))) lost_set = 1'b1;
    end else if (spike_in || window_end) begin
      lost_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLASSES; i++) begin
        if (handshake) begin
          cnt[i] <= '0;
        end else if ((state == ST_ACCUM) && spike_in && addr_ok &&
                     (addr_in == 3'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACCUM;
      idx         <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      class_valid <= 1'b0;
      class_out   <= '0;
      max_count   <= '0;
      lost        <= 1'b0;
    end else begin
      // set wins over the handshake clear so a late event lands in the new window
      lost <= lost_set | (lost & ~handshake);
      case (state)
        ST_ACCUM: begin
          if (window_end) begin
            state    <= ST_SCAN;
            idx      <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (scan_gt) begin
            best_idx <= idx;
            best_cnt <= scan_cnt;
          end
          if (idx == LAST_IDX) begin
            class_valid <= 1'b1;
            class_out   <= scan_gt ? idx : best_idx;
            max_count   <= scan_gt ? scan_cnt : best_cnt;
            state       <= ST_HOLD;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_HOLD: begin
          if (result_ready) begin
            class_valid <= 1'b0;
            state       <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_class_decoder.sv
// Directed bench for spike_class_decoder: a table of whole windows (spike
// counts per address with the expected argmax result) plus hand-written
// sequences for reset, back-pressure and the window boundary.
module tb_spike_class_decoder;

  logic       clk;
  logic       rst_n;
  logic       spike_in;
  logic [2:0] addr_in;
  logic       window_end;
  logic       result_ready;
  logic       class_valid;
  logic [2:0] class_out;
  logic [7:0] max_count;
  logic       lost;
  logic       busy;

  int total  = 0;
  int passed = 0;

  spike_class_decoder #(.N_CLASSES(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spike_in     (spike_in),
    .addr_in      (addr_in),
    .window_end   (window_end),
    .result_ready (result_ready),
    .class_valid  (class_valid),
    .class_out    (class_out),
    .max_count    (max_count),
    .lost         (lost),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][8:0] n;
    logic [2:0]      cls;
    logic [7:0]      mx;
    logic            lst;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spikes(input logic [2:0] a, input int count);
    for (int k = 0; k < count; k++) begin
      spike_in = 1'b1;
      addr_in  = a;
      step();
    end
    spike_in = 1'b0;
  endtask

  // pulse window_end (optionally with a spike) and return cycles until class_valid
  task automatic close_window(input logic with_spike, input logic [2:0] a, output int lat);
    window_end = 1'b1;
    spike_in   = with_spike;
    addr_in    = a;
    step();
    window_end = 1'b0;
    spike_in   = 1'b0;
    lat = 0;
    while (!class_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake(input logic with_spike, input logic [2:0] a);
    result_ready = 1'b1;
    spike_in     = with_spike;
    addr_in      = a;
    step();
    result_ready = 1'b0;
    spike_in     = 1'b0;
  endtask

  int lat;
  int stable_ok;

  initial begin
    rst_n = 1'b0; spike_in = 1'b0; addr_in = '0; window_end = 1'b0; result_ready = 1'b0;

    for (int i = 0; i < 5; i++) vecs[i].n = '0;
    vecs[0].n[3] = 9'd5;   vecs[0].n[6] = 9'd2;   vecs[0].cls = 3'd3; vecs[0].mx = 8'd5;   vecs[0].lst = 1'b0;
    vecs[1].n[5] = 9'd4;   vecs[1].n[2] = 9'd4;   vecs[1].cls = 3'd2; vecs[1].mx = 8'd4;   vecs[1].lst = 1'b0;
                                                  vecs[2].cls = 3'd0; vecs[2].mx = 8'd0;   vecs[2].lst = 1'b0;
    vecs[3].n[7] = 9'd300;                        vecs[3].cls = 3'd7; vecs[3].mx = 8'd255; vecs[3].lst = 1'b1;
    vecs[4].n[0] = 9'd1;   vecs[4].n[1] = 9'd3;   vecs[4].n[4] = 9'd3;
                                                  vecs[4].cls = 3'd1; vecs[4].mx = 8'd3;   vecs[4].lst = 1'b0;

    #12;
    chk("rst_valid", class_valid, 0);
    chk("rst_class", class_out, 0);
    chk("rst_max",   max_count, 0);
    chk("rst_lost",  lost, 0);
    chk("rst_busy",  busy, 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < 8; a++) spikes(3'(a), int'(vecs[v].n[a]));
      close_window(1'b0, 3'd0, lat);
      chk($sformatf("v%0d_latency", v), lat, 8);
      chk($sformatf("v%0d_class", v), class_out, vecs[v].cls);
      chk($sformatf("v%0d_max", v), max_count, vecs[v].mx);
      chk($sformatf("v%0d_lost", v), lost, vecs[v].lst);
      chk($sformatf("v%0d_busy_hold", v), busy, 1);
      handshake(1'b0, 3'd0);
      chk($sformatf("v%0d_valid_after", v), class_valid, 0);
      chk($sformatf("v%0d_lost_after", v), lost, 0);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
    end

    // reset in the middle of a scan: no result, counters cleared
    spikes(3'd2, 3);
    window_end = 1'b1;
    step();
    window_end = 1'b0;
    step(); step(); step();
    chk("midscan_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("midscan_rst_valid", class_valid, 0);
    chk("midscan_rst_busy",  busy, 0);
    chk("midscan_rst_max",   max_count, 0);
    step();
    rst_n = 1'b1;
    stable_ok = 1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (class_valid) stable_ok = 0;
    end
    chk("midscan_no_result", stable_ok, 1);
    spikes(3'd4, 1);
    close_window(1'b0, 3'd0, lat);
    chk("post_rst_class", class_out, 4);
    chk("post_rst_max",   max_count, 1);
    handshake(1'b0, 3'd0);

    // back-pressure: result held while spikes and a second window_end are dropped
    spikes(3'd6, 2);
    close_window(1'b0, 3'd0, lat);
    chk("bp_latency", lat, 8);
    stable_ok = 1;
    for (int k = 0; k < 20; k++) begin
      spike_in   = 1'b1;
      addr_in    = 3'd6;
      window_end = (k == 10);
      step();
      if (!class_valid || class_out !== 3'd6 || max_count !== 8'd2 || !busy) stable_ok = 0;
    end
    spike_in = 1'b0; window_end = 1'b0;
    chk("bp_stable", stable_ok, 1);
    chk("bp_lost", lost, 1);
    handshake(1'b0, 3'd0);
    chk("bp_lost_cleared", lost, 0);
    spikes(3'd0, 1);
    close_window(1'b0, 3'd0, lat);
    chk("bp_next_class", class_out, 0);
    chk("bp_next_max",   max_count, 1);
    handshake(1'b0, 3'd0);

    // spike coinciding with window_end counts; spike in the handshake cycle does not
    spikes(3'd1, 2);
    spikes(3'd5, 2);
    close_window(1'b1, 3'd1, lat);
    chk("bnd_class", class_out, 1);
    chk("bnd_max",   max_count, 3);
    chk("bnd_lost",  lost, 0);
    handshake(1'b1, 3'd0);
    chk("bnd_valid_after", class_valid, 0);
    chk("bnd_lost_new_window", lost, 1);
    spikes(3'd3, 1);
    close_window(1'b0, 3'd0, lat);
    chk("bnd_next_class", class_out, 3);
    chk("bnd_next_max",   max_count, 1);
    chk("bnd_next_lost",  lost, 1);
    handshake(1'b0, 3'd0);
    chk("bnd_final_lost", lost, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
